mant_norm_round: RTL and testbench

Post-multiply normalize-and-round stage for the mantissa datapath. Sits directly downstream of the mantissa multiplier: it consumes the raw 2*DWIDTH-bit mantissa product plus the pre-computed exponent and sign, and produces a DWIDTH-bit normalized, rounded mantissa with the adjusted exponent. It is a 2-stage valid/ready pipeline with full backpressure, so the multiplier output can be throttled by downstream packing logic.

---
 rtl/mant_norm_round_if.sv | 28 ++
 rtl/mant_norm_round.sv | 161 ++++++++++++++++
 tb/tb_mant_norm_round.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mant_norm_round_if.sv
// Valid/ready bundle carrying the raw mantissa product into mant_norm_round
// and the normalized, rounded result out of it.
interface mant_norm_round_if #(
  parameter int DWIDTH = 11,
  parameter int EWIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*DWIDTH-1:0]   in_prod;
  logic [EWIDTH-1:0]     in_exp;
  logic                  in_sign;
  logic                  out_valid;
  logic                  out_ready;
  logic [DWIDTH-1:0]     out_mant;
  logic [EWIDTH-1:0]     out_exp;
  logic                  out_sign;
  logic                  out_ovf;

  modport master (
    output in_valid, in_prod, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sign, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sign, out_ovf
  );
endinterface

// File: rtl/mant_norm_round.sv
// Two-stage normalize/round pipeline behind the mantissa multiplier.
// Define MANT_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module mant_norm_round #(
  parameter int DWIDTH = 11,
  parameter int EWIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  mant_norm_round_if.slave bus
);
  localparam int M = 2*DWIDTH-1;
  localparam logic [EWIDTH:0]   EXP_MAX    = (EWIDTH+1)'((1 << (EWIDTH-1)) - 1);
  localparam logic [DWIDTH-1:0] MANT_CARRY = {1'b1, {(DWIDTH-1){1'b0}}};

  logic              s1_valid_r;
  logic              s2_valid_r;
  logic              s2_adv_s;
  logic              accept_s;
  logic [DWIDTH-1:0] norm_mant_s;
  logic              norm_inc_s;
  logic [DWIDTH-1:0] s1_mant_r;
  logic              s1_inc_r;
  logic [EWIDTH-1:0] s1_exp_r;
  logic              s1_sign_r;
  logic              round_up_s;
  logic [DWIDTH:0]   rnd_sum_s;
  logic [DWIDTH-1:0] rnd_mant_s;
  logic              inc2_s;
  logic [EWIDTH:0]   exp_sum_s;
  logic              ovf_s;
  logic [EWIDTH-1:0] exp_sat_s;
  logic [DWIDTH-1:0] s2_mant_r;
  logic [EWIDTH-1:0] s2_exp_r;
  logic              s2_sign_r;
  logic              s2_ovf_r;

  assign s2_adv_s     = !s2_valid_r || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid_r || s2_adv_s);
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Normalize: at most a one-bit right shift when the product reached [2,4).
  always_comb begin
    norm_mant_s = '0;
    norm_inc_s  = 1'b0;
    if (bus.in_prod[M]) begin
      norm_mant_s = bus.in_prod[M:DWIDTH];
      norm_inc_s  = 1'b1;
    end else begin
      norm_mant_s = bus.in_prod[M-1:DWIDTH-1];
      norm_inc_s  = 1'b0;
    end
  end

`ifdef MANT_RNE_EN
  logic norm_g_s;
  logic norm_s_s;
  logic s1_g_r;
  logic s1_s_r;

  // Guard and sticky bits below the kept mantissa.
  always_comb begin
    norm_g_s = 1'b0;
    norm_s_s = 1'b0;
    if (bus.in_prod[M]) begin
      norm_g_s = bus.in_prod[DWIDTH-1];
      norm_s_s = |bus.in_prod[DWIDTH-2:0];
    end else begin
      norm_g_s = bus.in_prod[DWIDTH-2];
      norm_s_s = |bus.in_prod[DWIDTH-3:0];
    end
  end

  // Stage-1 rounding bits travel with the stage-1 mantissa.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_g_r <= 1'b0;
      s1_s_r <= 1'b0;
    end else if (accept_s) begin
      s1_g_r <= norm_g_s;
      s1_s_r <= norm_s_s;
    end else begin
      s1_g_r <= s1_g_r;
      s1_s_r <= s1_s_r;
    end
  end

  assign round_up_s = s1_g_r && (s1_s_r || s1_mant_r[0]);
`else
  logic unused_lsb_s;
  assign unused_lsb_s = ^bus.in_prod[DWIDTH-2:0];
  assign round_up_s   = 1'b0;
`endif

  // Round, renormalize on carry-out and saturate the exponent.
  always_comb begin
    rnd_sum_s = {1'b0, s1_mant_r} + {{DWIDTH{1'b0}}, round_up_s};
    inc2_s    = rnd_sum_s[DWIDTH];
    if (inc2_s) begin
      rnd_mant_s = MANT_CARRY;
    end else begin
      rnd_mant_s = rnd_sum_s[DWIDTH-1:0];
    end
    exp_sum_s = {s1_exp_r[EWIDTH-1], s1_exp_r} + {{EWIDTH{1'b0}}, s1_inc_r}
              + {{EWIDTH{1'b0}}, inc2_s};
    if ($signed(exp_sum_s) > $signed(EXP_MAX)) begin
      ovf_s     = 1'b1;
      exp_sat_s = EXP_MAX[EWIDTH-1:0];
    end else begin
      ovf_s     = 1'b0;
      exp_sat_s = exp_sum_s[EWIDTH-1:0];
    end
  end

  // Stage-1 register: loads on accept, empties when its entry moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_mant_r  <= '0;
      s1_inc_r   <= 1'b0;
      s1_exp_r   <= '0;
      s1_sign_r  <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_mant_r  <= norm_mant_s;
      s1_inc_r   <= norm_inc_s;
      s1_exp_r   <= bus.in_exp;
      s1_sign_r  <= bus.in_sign;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage-2 register drives the outputs directly and holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_mant_r  <= '0;
      s2_exp_r   <= '0;
      s2_sign_r  <= 1'b0;
      s2_ovf_r   <= 1'b0;
    end else if (s2_adv_s && s1_valid_r) begin
      s2_valid_r <= 1'b1;
      s2_mant_r  <= rnd_mant_s;
      s2_exp_r   <= exp_sat_s;
      s2_sign_r  <= s1_sign_r;
      s2_ovf_r   <= ovf_s;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_mant  = s2_mant_r;
  assign bus.out_exp   = s2_exp_r;
  assign bus.out_sign  = s2_sign_r;
  assign bus.out_ovf   = s2_ovf_r;
endmodule

// File: tb/tb_mant_norm_round.sv
// Self-checking bench for mant_norm_round: directed plan cases, backpressure,
// reset with data in flight and a randomized scoreboard run.
module tb_mant_norm_round;
  typedef struct packed {
    logic [10:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mant_norm_round_if #(.DWIDTH(11), .EWIDTH(8)) bus_if ();

  mant_norm_round #(.DWIDTH(11), .EWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference: value-level normalize then round via remainder vs. half-ulp.
  function automatic res_t ref_model(input logic [21:0] prod, input logic [7:0] e, input logic s);
    res_t r;
    int unsigned p, shift, mant;
    int ex;
`ifdef MANT_RNE_EN
    int unsigned rem, half;
`endif
    p     = prod;
    shift = (p >= (32'd1 << 21)) ? 11 : 10;
    mant  = p >> shift;
    ex    = int'($signed(e)) + ((shift == 11) ? 1 : 0);
`ifdef MANT_RNE_EN
    rem  = p % (32'd1 << shift);
    half = 32'd1 << (shift - 1);
    if (rem > half || (rem == half && (mant % 2) == 1)) mant = mant + 1;
    if (mant == 2048) begin
      mant = 1024;
      ex   = ex + 1;
    end
`endif
    r.ovf  = (ex > 127);
    if (ex > 127) ex = 127;
    r.mant = 11'(mant);
    r.exp  = 8'(ex);
    r.sign = s;
    return r;
  endfunction

  task automatic drive_one(input logic [21:0] p, input logic [7:0] e, input logic s);
    bus_if.in_prod   = p;
    bus_if.in_exp    = e;
    bus_if.in_sign   = s;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready);
    end
    checks++;
    if ({bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b m=%h e=%h s=%b o=%b want all zero",
               bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_if.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b want 1", bus_if.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    bus_if.in_prod   = 22'h100000;
    bus_if.in_exp    = 8'd0;
    bus_if.in_sign   = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid: got %b want 0", bus_if.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf}
        !== {1'b1, 11'h400, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic: got v=%b m=%h e=%h s=%b o=%b want v=1 m=400 e=00 s=1 o=0",
               bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf);
    end
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_single_emit: got %b want 0", bus_if.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [21:0] dp [6] = '{22'h300000, 22'h1FFE00, 22'h100200, 22'h100600, 22'h300000, 22'h300000};
    logic [7:0]  de [6] = '{8'd5, 8'd3, 8'd0, 8'd0, 8'd127, 8'h80};
`ifdef MANT_RNE_EN
    logic [10:0] xm [6] = '{11'h600, 11'h400, 11'h400, 11'h402, 11'h600, 11'h600};
    logic [7:0]  xe [6] = '{8'd6, 8'd4, 8'd0, 8'd0, 8'd127, 8'h81};
`else
    logic [10:0] xm [6] = '{11'h600, 11'h7FF, 11'h400, 11'h401, 11'h600, 11'h600};
    logic [7:0]  xe [6] = '{8'd6, 8'd3, 8'd0, 8'd0, 8'd127, 8'h81};
`endif
    logic        xo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive_one(dp[i], de[i], i[0]);
      checks++;
      if ({bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf}
          !== {1'b1, xm[i], xe[i], i[0], xo[i]}) begin
        errors++;
        $display("FAIL directed_%0d: got v=%b m=%h e=%h s=%b o=%b want v=1 m=%h e=%h s=%b o=%b",
                 i, bus_if.out_valid, bus_if.out_mant, bus_if.out_exp, bus_if.out_sign,
                 bus_if.out_ovf, xm[i], xe[i], i[0], xo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] p [4];
    logic [7:0]  e [4];
    logic        s [4];
    res_t        x [4];
    int idx = 0;
    int got = 0;
    for (int i = 0; i < 4; i++) begin
      p[i] = 22'($urandom); e[i] = 8'($urandom_range(0, 100)); s[i] = 1'($urandom);
      x[i] = ref_model(p[i], e[i], s[i]);
    end
    bus_if.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus_if.in_valid = (idx < 4);
      bus_if.in_prod  = p[idx % 4]; bus_if.in_exp = e[idx % 4]; bus_if.in_sign = s[idx % 4];
      #1;
      if (bus_if.out_valid === 1'b1) begin
        checks++;
        if ({bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf} !== x[0]) begin
          errors++;
          $display("FAIL stall_hold: got m=%h e=%h s=%b o=%b want m=%h e=%h s=%b o=%b",
                   bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf,
                   x[0].mant, x[0].exp, x[0].sign, x[0].ovf);
        end
      end
      if (bus_if.in_valid && bus_if.in_ready) idx++;
      @(negedge clk);
    end
    checks++;
    if (idx != 2 || bus_if.in_ready !== 1'b0 || bus_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL capacity: got accepted=%0d in_ready=%b out_valid=%b want 2/0/1",
               idx, bus_if.in_ready, bus_if.out_valid);
    end
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 4; c++) begin
      bus_if.in_valid = (idx < 4);
      bus_if.in_prod  = p[idx % 4]; bus_if.in_exp = e[idx % 4]; bus_if.in_sign = s[idx % 4];
      #1;
      if (bus_if.out_valid === 1'b1) begin
        checks++;
        if ({bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf} !== x[got]) begin
          errors++;
          $display("FAIL release_order_%0d: got m=%h e=%h s=%b o=%b want m=%h e=%h s=%b o=%b", got,
                   bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf,
                   x[got].mant, x[got].exp, x[got].sign, x[got].ovf);
        end
        got++;
      end
      if (bus_if.in_valid && bus_if.in_ready) idx++;
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++; $display("FAIL release_count: got %0d results want 4", got);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_flight();
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.in_prod = 22'($urandom); bus_if.in_exp = 8'd1; bus_if.in_sign = 1'b0;
      bus_if.in_valid = 1'b1;
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush: got out_valid=%b in_ready=%b want 0/0", bus_if.out_valid, bus_if.in_ready);
    end
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus_if.out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_no_emit_%0d: got out_valid=%b want 0", c, bus_if.out_valid);
      end
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t x;
    res_t g;
    bus_if.in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus_if.out_ready = ($urandom_range(0, 3) != 0);
      if (!bus_if.in_valid) begin
        case ($urandom_range(0, 3))
          0: bus_if.in_prod = (22'($urandom) & 22'h3FFC00) | 22'h000200;
          1: bus_if.in_prod = 22'h1FFC00 | 22'($urandom_range(0, 1023));
          2: bus_if.in_prod = 22'h200000 | 22'($urandom);
          default: bus_if.in_prod = 22'($urandom);
        endcase
        bus_if.in_exp   = 8'($urandom);
        bus_if.in_sign  = 1'($urandom);
        bus_if.in_valid = (c < 380) && ($urandom_range(0, 3) != 0);
      end
      #1;
      if (bus_if.out_valid === 1'b1 && bus_if.out_ready) begin
        g = {bus_if.out_mant, bus_if.out_exp, bus_if.out_sign, bus_if.out_ovf};
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL random_spurious: got m=%h with no pending entry", g.mant);
        end else begin
          x = q.pop_front();
          if (g !== x) begin
            errors++;
            $display("FAIL random_result: got m=%h e=%h s=%b o=%b want m=%h e=%h s=%b o=%b",
                     g.mant, g.exp, g.sign, g.ovf, x.mant, x.exp, x.sign, x.ovf);
          end
        end
      end
      if (bus_if.in_valid && bus_if.in_ready)
        q.push_back(ref_model(bus_if.in_prod, bus_if.in_exp, bus_if.in_sign));
      @(negedge clk);
      if (bus_if.in_valid && q.size() > 0 && bus_if.in_ready === 1'b0) begin
        bus_if.in_valid = 1'b1;
      end else begin
        bus_if.in_valid = 1'b0;
      end
    end
    checks++;
    if (q.size() != 0 || bus_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got %0d pending, out_valid=%b want 0/0", q.size(), bus_if.out_valid);
    end
  endtask

  initial begin
    bus_if.in_valid  = 1'b0;
    bus_if.in_prod   = '0;
    bus_if.in_exp    = '0;
    bus_if.in_sign   = 1'b0;
    bus_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_directed();
    test_backpressure();
    test_reset_in_flight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
